controlador_de_bus: RTL and testbench

//   Sequences one memory bus cycle per request from the control unit. Drives the
//   2-bit output-select code into the output manager (00 idle, 01 load [RY],
//   10 store Num->[RX], 11 store RX->[RY]) and holds it stable across setup,

---
 rtl/controlador_de_bus.sv | 159 +++++++++++++++
 tb/tb_controlador_de_bus.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_de_bus.sv
// -----------------------------------------------------------------------------
// controlador_de_bus
//   Runs one memory bus cycle for each request from the control unit. It holds
//   the output-select code stable through the setup, strobe and hold phases. It
//   waits for the memory ack for a limited number of cycles, captures load data,
//   and reports completion or a timeout.
//
//   Select / op encoding: 00 idle, 01 load [RY], 10 store Num->[RX],
//                         11 store RX->[RY]
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active high
//   i_req          in   request, looked at only while idle
//   i_op [1:0]     in   op code (00 = no-op, ignored)
//   i_mem_ack      in   memory acknowledge, looked at only while strobing
//   i_datain [7:0] in   memory read data, valid together with i_mem_ack on a load
//   o_sel_salidas  out  select code to the output manager
//   o_mem_strobe   out  memory cycle strobe
//   o_busy         out  high from setup through recover
//   o_done         out  1-cycle pulse at the end of every accepted request
//   o_error        out  1-cycle pulse together with o_done on timeout
//   o_rdata [7:0]  out  last byte that was loaded successfully
//   o_rdata_valid  out  1-cycle pulse together with o_done on a successful load
// -----------------------------------------------------------------------------
module controlador_de_bus #(
    parameter int SETUP_CYC   = 1,   // select-to-strobe cycles, >= 1
    parameter int TIMEOUT_CYC = 15,  // strobe cycles allowed for ack, 0 = wait forever
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [1:0] i_op,
    input  logic       i_mem_ack,
    input  logic [7:0] i_datain,
    output logic [1:0] o_sel_salidas,
    output logic       o_mem_strobe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;

    // Counter values seen in the final cycle of each timed phase.
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam bit               HAS_TIMEOUT  = (TIMEOUT_CYC != 0);

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       sel_reg;
    logic             strobe_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic [7:0]       rdata_reg;
    logic             rdata_valid_reg;

    // Every output is registered and is set on the state transition that enters
    // the phase where it applies. This keeps the outputs aligned with the state
    // and removes any combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            op_reg          <= 2'b00;
            cnt_reg         <= '0;
            sel_reg         <= 2'b00;
            strobe_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            rdata_reg       <= 8'h00;
            rdata_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg        <= 1'b0;
                    error_reg       <= 1'b0;
                    rdata_valid_reg <= 1'b0;
                    if (i_req && (i_op != 2'b00)) begin
                        op_reg    <= i_op;
                        sel_reg   <= i_op;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        cnt_reg    <= '0;
                        strobe_reg <= 1'b1;
                        state_reg  <= ST_STROBE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_STROBE: begin
                    // If the ack arrives in the last allowed cycle, it wins over the timeout.
                    if (i_mem_ack) begin
                        strobe_reg      <= 1'b0;
                        done_reg        <= 1'b1;
                        error_reg       <= 1'b0;
                        rdata_valid_reg <= (op_reg == OP_LOAD);
                        if (op_reg == OP_LOAD) begin
                            rdata_reg <= i_datain;
                        end
                        state_reg <= ST_RECOVER;
                    end else if (HAS_TIMEOUT && (cnt_reg == TIMEOUT_LAST)) begin
                        strobe_reg      <= 1'b0;
                        done_reg        <= 1'b1;
                        error_reg       <= 1'b1;
                        rdata_valid_reg <= 1'b0;
                        state_reg       <= ST_RECOVER;
                    end else if (HAS_TIMEOUT) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    // Select stays valid through this hold cycle and is released afterwards.
                    done_reg        <= 1'b0;
                    error_reg       <= 1'b0;
                    rdata_valid_reg <= 1'b0;
                    sel_reg         <= 2'b00;
                    busy_reg        <= 1'b0;
                    cnt_reg         <= '0;
                    state_reg       <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sel_salidas = sel_reg;
    assign o_mem_strobe  = strobe_reg;
    assign o_busy        = busy_reg;
    assign o_done        = done_reg;
    assign o_error       = error_reg;
    assign o_rdata       = rdata_reg;
    assign o_rdata_valid = rdata_valid_reg;

endmodule

// File: tb/tb_controlador_de_bus.sv
// -----------------------------------------------------------------------------
// tb_controlador_de_bus
//   Self-checking bench for controlador_de_bus. The bench samples outputs on the
//   falling edge and drives inputs right after sampling. Each bus transaction is
//   summarised as per-cycle counts, and these are compared with values derived
//   from the transaction's op code and the cycle in which ack is offered.
// -----------------------------------------------------------------------------
module tb_controlador_de_bus;

    localparam int SETUP_CYC   = 1;
    localparam int TIMEOUT_CYC = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_req;
    logic [1:0] i_op;
    logic       i_mem_ack;
    logic [7:0] i_datain;
    logic [1:0] o_sel_salidas;
    logic       o_mem_strobe;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_rdata;
    logic       o_rdata_valid;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: the byte that should be visible on o_rdata.
    logic [7:0] model_rdata;

    controlador_de_bus #(
        .SETUP_CYC   (SETUP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_op          (i_op),
        .i_mem_ack     (i_mem_ack),
        .i_datain      (i_datain),
        .o_sel_salidas (o_sel_salidas),
        .o_mem_strobe  (o_mem_strobe),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one request. ack_at is the strobe cycle (1-based) in which ack is
    // offered. 0 means no ack. Values beyond the timeout land after the
    // timeout has already happened. busy_req keeps i_req=1 with op=01 during
    // the first busy cycles to show that those requests are dropped.
    // spurious_ack raises ack during setup, where it must be ignored.
    task automatic run_txn(input string name, input logic [1:0] op, input int ack_at,
                           input logic [7:0] data, input bit busy_req, input bit spurious_ack);
        int  strobes;
        bit  timeout;
        int  done_exp;
        int  strobe_cnt = 0;
        int  sel_cnt    = 0;
        int  busy_cnt   = 0;
        int  done_cnt   = 0;
        int  done_cyc   = -1;
        int  err_cnt    = 0;
        int  err_with_done = 0;
        int  valid_cnt  = 0;
        logic [1:0] sel_after  = 2'bxx;
        logic       busy_after = 1'bx;

        // Expected behaviour, derived from the op code and the ack cycle.
        timeout  = !(ack_at >= 1 && ack_at <= TIMEOUT_CYC);
        strobes  = timeout ? TIMEOUT_CYC : ack_at;
        done_exp = SETUP_CYC + strobes + 1;
        if (op == 2'b01 && !timeout) model_rdata = data;

        i_req = 1'b1;
        i_op  = op;
        @(negedge clk);
        for (int c = 1; c <= done_exp + 2; c++) begin
            // Sample this cycle's outputs.
            if (o_mem_strobe) strobe_cnt++;
            if (o_sel_salidas == op) sel_cnt++;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (o_error) err_cnt++;
            if (o_error && o_done) err_with_done++;
            if (o_rdata_valid) valid_cnt++;
            if (c == done_exp + 1) begin
                sel_after  = o_sel_salidas;
                busy_after = o_busy;
            end
            // Drive inputs for the edge that ends this cycle.
            i_req     = busy_req && (c <= 2);
            i_op      = (busy_req && (c <= 2)) ? 2'b01 : 2'b00;
            i_mem_ack = (ack_at > 0 && c == SETUP_CYC + ack_at) ||
                        (spurious_ack && c <= SETUP_CYC);
            i_datain  = (ack_at > 0 && c == SETUP_CYC + ack_at) ? data : 8'($urandom);
            @(negedge clk);
        end
        i_req     = 1'b0;
        i_op      = 2'b00;
        i_mem_ack = 1'b0;

        check({name, ".strobe_cycles"}, strobe_cnt, strobes);
        check({name, ".sel_cycles"},    sel_cnt,    done_exp);
        check({name, ".busy_cycles"},   busy_cnt,   done_exp);
        check({name, ".done_count"},    done_cnt,   1);
        check({name, ".done_cycle"},    done_cyc,   done_exp);
        check({name, ".error_count"},   err_cnt,    timeout ? 1 : 0);
        check({name, ".error_with_done"}, err_with_done, timeout ? 1 : 0);
        check({name, ".rdata_valid"},   valid_cnt,  (op == 2'b01 && !timeout) ? 1 : 0);
        check({name, ".sel_after"},     sel_after,  2'b00);
        check({name, ".busy_after"},    busy_after, 1'b0);
        check({name, ".rdata"},         o_rdata,    model_rdata);
        $display("txn %s op=%0d ack_at=%0d strobes=%0d done@%0d err=%0d rdata=%02h",
                 name, op, ack_at, strobe_cnt, done_cyc, err_cnt, o_rdata);
    endtask

    initial begin
        int n_done;
        logic [1:0] rop;
        int         rack;

        rst = 1'b1; i_req = 1'b0; i_op = 2'b00; i_mem_ack = 1'b0; i_datain = 8'h00;
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.sel",    o_sel_salidas, 2'b00);
        check("rst.strobe", o_mem_strobe,  1'b0);
        check("rst.busy",   o_busy,        1'b0);
        check("rst.done",   o_done,        1'b0);
        check("rst.error",  o_error,       1'b0);
        check("rst.rdata",  o_rdata,       8'h00);
        check("rst.valid",  o_rdata_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn("load_ack1",  2'b01, 1,  8'hA5, 1'b0, 1'b0);
        run_txn("store_ack5", 2'b10, 5,  8'h3C, 1'b0, 1'b1);
        run_txn("store_to",   2'b11, 0,  8'h00, 1'b0, 1'b0);
        run_txn("load_ack15", 2'b01, 15, 8'h5A, 1'b0, 1'b0);
        run_txn("load_to",    2'b01, 16, 8'hEE, 1'b0, 1'b0);
        run_txn("busy_req",   2'b10, 3,  8'h11, 1'b1, 1'b0);

        // A no-op request in idle is ignored.
        n_done = 0;
        i_req = 1'b1; i_op = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_done || o_busy) n_done++;
        end
        i_req = 1'b0;
        check("noop.ignored", n_done, 0);
        $display("txn noop_req busy_or_done_cycles=%0d", n_done);

        // Reset during strobe aborts the cycle without a done pulse.
        i_req = 1'b1; i_op = 2'b11;
        @(negedge clk);
        i_req = 1'b0; i_op = 2'b00;
        repeat (3) @(negedge clk);
        check("abort.strobe_before", o_mem_strobe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort.strobe", o_mem_strobe,  1'b0);
        check("abort.sel",    o_sel_salidas, 2'b00);
        check("abort.busy",   o_busy,        1'b0);
        check("abort.done",   o_done,        1'b0);
        rst = 1'b0;
        model_rdata = 8'h00;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_done || o_error) n_done++;
        end
        check("abort.no_done", n_done, 0);
        check("abort.rdata",   o_rdata, 8'h00);
        $display("txn reset_abort done_after=%0d", n_done);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            rop  = 2'($urandom_range(3, 1));
            rack = $urandom_range(16, 0);
            run_txn($sformatf("rnd%0d", t), rop, rack, 8'($urandom),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
